// File: rtl/cmp_debounce_pkg.sv
// Shared types and decode helper for the comparator-result debouncer.
package cmp_debounce_pkg;

    typedef logic [1:0] rel_t;

    localparam rel_t REL_UNKNOWN = 2'b00;
    localparam rel_t REL_EQ      = 2'b01;
    localparam rel_t REL_GT      = 2'b10;
    localparam rel_t REL_LT      = 2'b11;

    typedef struct packed {
        logic legal;
        rel_t rel;
    } dec_t;

    // Map a one-hot {eq,gt,lt} code to a relation; anything not one-hot is illegal.
    function automatic dec_t decode_rel(input logic [2:0] code);
        dec_t d;
        d.legal = 1'b1;
        d.rel   = REL_UNKNOWN;
        case (code)
            3'b100:  d.rel = REL_EQ;
            3'b010:  d.rel = REL_GT;
            3'b001:  d.rel = REL_LT;
            default: d.legal = 1'b0;
        endcase
        return d;
    endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear.
module sat_counter #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         inc,
    output logic [W-1:0] q
);

    logic [W-1:0] cnt_q;

    // Count up on inc, hold at all-ones, clear has priority.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (inc && (cnt_q != {W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign q = cnt_q;

endmodule

// File: rtl/compare_debounce.sv
// Debounces the comparator's one-hot eq/gt/lt stream into a committed relation.
module compare_debounce
    import cmp_debounce_pkg::*;
#(
    parameter int unsigned STABLE_CNT = 4,
    parameter int unsigned CNT_W      = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    input  logic             eq,
    input  logic             gt,
    input  logic             lt,
    input  logic             clear,
    output logic [1:0]       state_out,
    output logic             state_valid,
    output logic             change_pulse,
    output logic             err,
    output logic [CNT_W-1:0] gt_events,
    output logic [CNT_W-1:0] lt_events
);

    localparam int unsigned RUN_W = $clog2(STABLE_CNT + 1);
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STABLE_CNT);
    localparam logic [RUN_W-1:0] RUN_LAST = RUN_W'(STABLE_CNT - 1);

    rel_t             state_q, state_d;
    rel_t             cand_q,  cand_d;
    logic [RUN_W-1:0] run_q,   run_d;
    logic             pulse_q, pulse_d;
    logic             err_q,   err_d;
    logic             gt_inc,  lt_inc;
    dec_t             dec;
    logic             reaches;

    // State register: committed relation, candidate run, pulse and sticky error.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= REL_UNKNOWN;
            cand_q  <= REL_UNKNOWN;
            run_q   <= '0;
            pulse_q <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cand_q  <= cand_d;
            run_q   <= run_d;
            pulse_q <= pulse_d;
            err_q   <= err_d;
        end
    end

    // Next-state: track the candidate run and commit once it has been stable long enough.
    always_comb begin
        state_d = state_q;
        cand_d  = cand_q;
        run_d   = run_q;
        pulse_d = 1'b0;
        err_d   = err_q;
        gt_inc  = 1'b0;
        lt_inc  = 1'b0;
        dec     = decode_rel({eq, gt, lt});
        reaches = 1'b0;

        if (clear) begin
            state_d = REL_UNKNOWN;
            cand_d  = REL_UNKNOWN;
            run_d   = '0;
            err_d   = 1'b0;
        end else if (in_valid) begin
            if (!dec.legal) begin
                err_d  = 1'b1;
                cand_d = REL_UNKNOWN;
                run_d  = '0;
            end else begin
                if (dec.rel == cand_q) begin
                    // Only the sample that lands exactly on the threshold commits.
                    reaches = (run_q == RUN_LAST);
                    if (run_q != RUN_MAX) begin
                        run_d = run_q + 1'b1;
                    end
                end else begin
                    cand_d  = dec.rel;
                    run_d   = RUN_W'(1);
                    reaches = (STABLE_CNT == 1);
                end
                if (reaches && (dec.rel != state_q)) begin
                    state_d = dec.rel;
                    pulse_d = 1'b1;
                    gt_inc  = (dec.rel == REL_GT);
                    lt_inc  = (dec.rel == REL_LT);
                end
            end
        end
    end

    // Outputs are driven straight from registers.
    always_comb begin
        state_out    = state_q;
        state_valid  = (state_q != REL_UNKNOWN);
        change_pulse = pulse_q;
        err          = err_q;
    end

    sat_counter #(.W(CNT_W)) u_gt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (gt_inc),
        .q     (gt_events)
    );

    sat_counter #(.W(CNT_W)) u_lt_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (clear),
        .inc   (lt_inc),
        .q     (lt_events)
    );

endmodule

// File: tb/tb_compare_debounce.sv
// Directed bench for compare_debounce: a STABLE_CNT=4 instance and a STABLE_CNT=1/CNT_W=2 instance.
module tb_compare_debounce;

    localparam logic [2:0] C_EQ  = 3'b100;
    localparam logic [2:0] C_GT  = 3'b010;
    localparam logic [2:0] C_LT  = 3'b001;
    localparam logic [2:0] C_BAD = 3'b110;

    logic clk = 1'b0;
    logic rst_n, in_valid, eq, gt, lt, clear;

    logic [1:0] a_state, b_state;
    logic       a_valid, b_valid, a_pulse, b_pulse, a_err, b_err;
    logic [7:0] a_gt, a_lt;
    logic [1:0] b_gt, b_lt;

    int n_checks = 0;
    int n_fails  = 0;

    always #5 clk = ~clk;

    compare_debounce #(.STABLE_CNT(4), .CNT_W(8)) dut_a (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .eq(eq), .gt(gt), .lt(lt),
        .clear(clear), .state_out(a_state), .state_valid(a_valid),
        .change_pulse(a_pulse), .err(a_err), .gt_events(a_gt), .lt_events(a_lt)
    );

    compare_debounce #(.STABLE_CNT(1), .CNT_W(2)) dut_b (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .eq(eq), .gt(gt), .lt(lt),
        .clear(clear), .state_out(b_state), .state_valid(b_valid),
        .change_pulse(b_pulse), .err(b_err), .gt_events(b_gt), .lt_events(b_lt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // One valid sample, accepted on the next rising edge; returns at the following falling edge.
    task automatic smp(input logic [2:0] c);
        {eq, gt, lt} = c;
        in_valid = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        {eq, gt, lt} = 3'b000;
    endtask

    task automatic idle(input int n);
        in_valid = 1'b0;
        repeat (n) @(negedge clk);
    endtask

    task automatic do_clear();
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
    endtask

    task automatic chk_a_zero(input string tag);
        chk({tag, "_state"}, 32'(a_state), 0);
        chk({tag, "_valid"}, 32'(a_valid), 0);
        chk({tag, "_pulse"}, 32'(a_pulse), 0);
        chk({tag, "_err"},   32'(a_err),   0);
        chk({tag, "_gt"},    32'(a_gt),    0);
        chk({tag, "_lt"},    32'(a_lt),    0);
    endtask

    initial begin
        int bgt, blt;
        rst_n = 1'b0; in_valid = 1'b0; clear = 1'b0;
        {eq, gt, lt} = 3'b000;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Reset state
        chk_a_zero("rst");
        chk("rst_b_state", 32'(b_state), 0);

        // Four GT samples: commit only on the fourth
        for (int i = 1; i <= 3; i++) begin
            smp(C_GT);
            chk($sformatf("gt4_s%0d_state", i), 32'(a_state), 0);
        end
        smp(C_GT);
        chk("gt4_state", 32'(a_state), 2);
        chk("gt4_valid", 32'(a_valid), 1);
        chk("gt4_pulse", 32'(a_pulse), 1);
        chk("gt4_gtcnt", 32'(a_gt), 1);
        idle(1);
        chk("gt4_pulse_drop", 32'(a_pulse), 0);
        chk("gt4_hold", 32'(a_state), 2);

        // GT x3, EQ, GT x4: run restarts twice, single commit
        do_clear();
        chk_a_zero("clr1");
        repeat (3) smp(C_GT);
        smp(C_EQ);
        chk("restart_eq_state", 32'(a_state), 0);
        repeat (3) smp(C_GT);
        chk("restart_gt3_state", 32'(a_state), 0);
        smp(C_GT);
        chk("restart_state", 32'(a_state), 2);
        chk("restart_pulse", 32'(a_pulse), 1);
        chk("restart_gtcnt", 32'(a_gt), 1);
        smp(C_GT);
        chk("sat_no_pulse", 32'(a_pulse), 0);
        chk("sat_no_count", 32'(a_gt), 1);

        // Gaps in in_valid do not break a run
        do_clear();
        repeat (2) smp(C_GT);
        idle(3);
        smp(C_GT);
        chk("gap_s3_state", 32'(a_state), 0);
        smp(C_GT);
        chk("gap_state", 32'(a_state), 2);
        chk("gap_pulse", 32'(a_pulse), 1);

        // Illegal code: sticky err, state holds
        smp(C_BAD);
        chk("bad_err", 32'(a_err), 1);
        chk("bad_state", 32'(a_state), 2);
        chk("bad_pulse", 32'(a_pulse), 0);
        repeat (3) smp(C_LT);
        chk("lt3_state", 32'(a_state), 2);
        smp(C_LT);
        chk("lt4_state", 32'(a_state), 3);
        chk("lt4_pulse", 32'(a_pulse), 1);
        chk("lt4_ltcnt", 32'(a_lt), 1);
        chk("lt4_gtcnt", 32'(a_gt), 1);
        chk("lt4_err", 32'(a_err), 1);

        // A fresh run equal to the committed state: no pulse, no count
        smp(3'b000);
        repeat (4) smp(C_LT);
        chk("same_pulse", 32'(a_pulse), 0);
        chk("same_ltcnt", 32'(a_lt), 1);
        chk("same_state", 32'(a_state), 3);

        do_clear();
        chk_a_zero("clr2");

        // STABLE_CNT=1, CNT_W=2: alternate GT/LT, pulse each cycle, counters saturate at 3
        bgt = 0; blt = 0;
        for (int i = 0; i < 10; i++) begin
            if (i % 2 == 0) begin
                smp(C_GT);
                bgt = (bgt < 3) ? bgt + 1 : 3;
                chk($sformatf("alt%0d_state", i), 32'(b_state), 2);
            end else begin
                smp(C_LT);
                blt = (blt < 3) ? blt + 1 : 3;
                chk($sformatf("alt%0d_state", i), 32'(b_state), 3);
            end
            chk($sformatf("alt%0d_pulse", i), 32'(b_pulse), 1);
            chk($sformatf("alt%0d_gtcnt", i), 32'(b_gt), 32'(bgt));
            chk($sformatf("alt%0d_ltcnt", i), 32'(b_lt), 32'(blt));
        end
        chk("alt_a_state", 32'(a_state), 0);
        smp(C_LT);
        chk("alt_repeat_pulse", 32'(b_pulse), 0);
        chk("alt_repeat_ltcnt", 32'(b_lt), 3);

        // Async reset mid-run discards partial run
        do_clear();
        repeat (4) smp(C_GT);
        chk("pre_rst_gtcnt", 32'(a_gt), 1);
        repeat (2) smp(C_LT);
        #2 rst_n = 1'b0;
        #1;
        chk_a_zero("async");
        chk("async_b_state", 32'(b_state), 0);
        chk("async_b_lt", 32'(b_lt), 0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) smp(C_LT);
        chk("postrst_lt3_state", 32'(a_state), 0);
        smp(C_LT);
        chk("postrst_lt4_state", 32'(a_state), 3);

        // clear wins over a simultaneous sample
        clear = 1'b1;
        {eq, gt, lt} = C_GT;
        in_valid = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        in_valid = 1'b0;
        {eq, gt, lt} = 3'b000;
        chk_a_zero("clrv");
        chk("clrv_b_state", 32'(b_state), 0);
        chk("clrv_b_pulse", 32'(b_pulse), 0);
        repeat (3) smp(C_GT);
        chk("clrv_gt3_state", 32'(a_state), 0);
        smp(C_GT);
        chk("clrv_gt4_state", 32'(a_state), 2);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
